// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS controller:
// opcodes/functs, FSM states, datapath select codes and the instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_RAM  = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_SLT  = 2'b11;

  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic addi;
    logic addiu;
    logic jal;
    logic unknown;
  } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to one-hot instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output instr_cls_t cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_o.addu    = 1'b1;
          FN_SUBU: cls_o.subu    = 1'b1;
          FN_SLT:  cls_o.slt     = 1'b1;
          FN_JR:   cls_o.jr      = 1'b1;
          default: cls_o.unknown = 1'b1;
        endcase
      end
      OP_J:     cls_o.j       = 1'b1;
      OP_JAL:   cls_o.jal     = 1'b1;
      OP_BEQ:   cls_o.beq     = 1'b1;
      OP_ADDI:  cls_o.addi    = 1'b1;
      OP_ADDIU: cls_o.addiu   = 1'b1;
      OP_ORI:   cls_o.ori     = 1'b1;
      OP_LUI:   cls_o.lui     = 1'b1;
      OP_LW:    cls_o.lw      = 1'b1;
      OP_SW:    cls_o.sw      = 1'b1;
      default:  cls_o.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS controller FSM and datapath strobes.
// Optional MC_ADDI_OVF_TRAP_EN: addi signed overflow suppresses the GPR write.
module mc_controller
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  output logic               PCWr,
  output logic               IRWr,
  output logic               RegWr,
  output logic               MemWr,
  output logic [1:0]         RegDst,
  output logic               ALUSrc,
  output logic [1:0]         Mem2Reg,
  output logic [1:0]         NPCSel,
  output logic [1:0]         EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state
);

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  instr_cls_t cls;

  mc_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .cls_o    (cls)
  );

  logic       is_rtype, is_jump, mem_last;
  logic [1:0] dec_alu_op, dec_ext_op;
  logic       dec_alu_src;

  assign is_rtype = cls.addu | cls.subu | cls.slt;
  assign is_jump  = cls.j | cls.jal | cls.jr | cls.unknown;
  assign mem_last = (cnt_q == CNT_LAST);

  always_comb begin
    dec_alu_op  = ALU_ADD;
    dec_ext_op  = EXT_ZERO;
    dec_alu_src = cls.ori | cls.lui | cls.lw | cls.sw | cls.addi | cls.addiu;
    if (cls.subu | cls.beq) dec_alu_op = ALU_SUB;
    if (cls.ori | cls.lui)  dec_alu_op = ALU_OR;
    if (cls.slt)            dec_alu_op = ALU_SLT;
    if (cls.addi | cls.addiu | cls.lw | cls.sw) dec_ext_op = EXT_SIGN;
    if (cls.lui)            dec_ext_op = EXT_LUI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src;
  logic [1:0] reg_dst, m2r, npc, ext_op, alu_op;

`ifndef MC_ADDI_OVF_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    alu_src = 1'b0;
    reg_dst = DST_RT;
    m2r     = M2R_ALU;
    npc     = NPC_PC4;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        ovf_d   = 1'b0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_jump) begin
          pc_wr   = 1'b1;
          state_d = S_FETCH;
          if (cls.j | cls.jal) npc = NPC_J;
          if (cls.jr)          npc = NPC_JR;
          if (cls.jal) begin
            reg_wr  = 1'b1;
            reg_dst = DST_RA;
            m2r     = M2R_PC4;
          end
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
`ifdef MC_ADDI_OVF_TRAP_EN
        if (cls.addi) ovf_d = overflow;
`endif
        if (cls.beq) begin
          pc_wr   = 1'b1;
          npc     = zero ? NPC_BR : NPC_PC4;
          state_d = S_FETCH;
        end else if (cls.lw | cls.sw) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
        cnt_d   = cnt_q + CNT_W'(1);
        if (mem_last) begin
          if (cls.sw) begin
            mem_wr  = 1'b1;
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
        reg_wr  = ~ovf_q;
        pc_wr   = 1'b1;
        reg_dst = is_rtype ? DST_RD : DST_RT;
        m2r     = cls.lw ? M2R_RAM : M2R_ALU;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output so an aborted instruction issues no partial writes.
  always_comb begin
    PCWr    = pc_wr  & ~rst;
    IRWr    = ir_wr  & ~rst;
    RegWr   = reg_wr & ~rst;
    MemWr   = mem_wr & ~rst;
    ALUSrc  = alu_src & ~rst;
    RegDst  = rst ? 2'b00 : reg_dst;
    Mem2Reg = rst ? 2'b00 : m2r;
    NPCSel  = rst ? 2'b00 : npc;
    EXTOp   = rst ? 2'b00 : ext_op;
    state   = rst ? 3'd0  : state_q;
    ALUOp   = '0;
    if (!rst) ALUOp[1:0] = alu_op;
  end

endmodule
